instr_encoder: RTL

//  Program loader / encoder: inverse of the instruction decoder. Accepts symbolic instruction

---
 rtl/mips_pkg.sv | 37 +++
 rtl/instr_word_pack.sv | 32 +++
 rtl/instr_encoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants for the program loader and the instruction decoder.
// Holds the symbolic op enum, opcode/func fields and the loader FSM state type.
package mips_pkg;

  typedef enum logic [3:0] {
    ENC_ADDU  = 4'd0,
    ENC_OR    = 4'd1,
    ENC_ADDIU = 4'd2,
    ENC_SW    = 4'd3,
    ENC_LW    = 4'd4,
    ENC_BNE   = 4'd5,
    ENC_J     = 4'd6,
    ENC_JAL   = 4'd7
  } enc_op_t;

  localparam logic [5:0] OPC_R     = 6'h00;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;

  localparam logic [5:0] FUNC_ADDU = 6'h21;
  localparam logic [5:0] FUNC_OR   = 6'h25;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PAD  = 1'b1
  } enc_state_t;

  // Ops whose word is followed by a branch delay slot.
  function automatic logic is_ctl_op(input logic [3:0] op);
    return (op == ENC_BNE) || (op == ENC_J) || (op == ENC_JAL);
  endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Combinational packer: symbolic op plus fields -> 32-bit MIPS word.
// word_o is zero and valid_o low for op codes outside the enc_op_t range.
module instr_word_pack
  import mips_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        valid_o
);

  always_comb begin
    word_o  = 32'h0000_0000;
    valid_o = 1'b1;
    case (op_i)
      ENC_ADDU:  word_o = {OPC_R, rs_i, rt_i, rd_i, 5'h00, FUNC_ADDU};
      ENC_OR:    word_o = {OPC_R, rs_i, rt_i, rd_i, 5'h00, FUNC_OR};
      ENC_ADDIU: word_o = {OPC_ADDIU, rs_i, rt_i, imm_i};
      ENC_SW:    word_o = {OPC_SW, rs_i, rt_i, imm_i};
      ENC_LW:    word_o = {OPC_LW, rs_i, rt_i, imm_i};
      ENC_BNE:   word_o = {OPC_BNE, rs_i, rt_i, imm_i};
      ENC_J:     word_o = {OPC_J, target_i};
      ENC_JAL:   word_o = {OPC_JAL, target_i};
      default:   valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs symbolic requests into MIPS words and writes them sequentially.
// Define INSTR_ENCODER_DELAY_SLOT_PAD_EN to append a nop after every BNE/J/JAL.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

`ifdef INSTR_ENCODER_DELAY_SLOT_PAD_EN
  localparam int FULL_AT = DEPTH - 1;
`else
  localparam int FULL_AT = DEPTH;
`endif
  localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W+1)'(FULL_AT);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   ONE      = (ADDR_W+1)'(1);

  enc_state_t        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       pk_word_s;
  logic              pk_valid_s;
  logic              accept_s;
  logic [ADDR_W-1:0] wr_addr_s;

  instr_word_pack u_pack (
    .op_i     (req_op),
    .rs_i     (req_rs),
    .rt_i     (req_rt),
    .rd_i     (req_rd),
    .imm_i    (req_imm),
    .target_i (req_target),
    .word_o   (pk_word_s),
    .valid_o  (pk_valid_s)
  );

  assign full      = (count_q >= FULL_LVL);
  assign req_ready = (state_q == ST_IDLE) && !full && !flush;
  assign accept_s  = req_valid && req_ready;
  assign wr_addr_s = BASE + count_q[ADDR_W-1:0];

  // flush wins over accept and pad; a write already on mem_we still completes.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (flush) begin
      state_d = ST_IDLE;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s && pk_valid_s) begin
            we_d    = 1'b1;
            addr_d  = wr_addr_s;
            wdata_d = pk_word_s;
            count_d = count_q + ONE;
`ifdef INSTR_ENCODER_DELAY_SLOT_PAD_EN
            state_d = is_ctl_op(req_op) ? ST_PAD : ST_IDLE;
`endif
          end else if (accept_s) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PAD: begin
`ifdef INSTR_ENCODER_DELAY_SLOT_PAD_EN
          we_d    = 1'b1;
          addr_d  = wr_addr_s;
          wdata_d = 32'h0000_0000;
          count_d = count_q + ONE;
`endif
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule
